tmr_scrub_ctrl: RTL and testbench

- Background scrubber for triplicated configuration/state registers in the readout block.
- Periodically walks all triplicated words and reads the three copies. Forms the bitwise 2-of-3 majority.
- When any copy disagrees, writes the voted value back to all three copies.
- Counts upsets and reports status to slow control.
- Sits between the slow-control register bank (the triplicated storage) and the readout status registers.

---
 rtl/tmr_scrub_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_tmr_scrub_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_scrub_ctrl.sv
// rtl/tmr_scrub_ctrl.sv - background 2-of-3 majority scrubber for triplicated register words
//
// Walks WORDS triplicated words in a pass, reads the three copies of each word,
// votes bitwise 2-of-3 and writes the voted value back when the copies disagree.
// Passes repeat after `interval` idle cycles while enable is high.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   enable                     scrubbing enabled (level)
//   interval                   idle cycles between passes, sampled on entry to WAIT
//   clear_err                  synchronous clear of err_count (wins over increment)
//   rd_req/rd_ack              read handshake; rd_a/rd_b/rd_c are the three copies
//   rd_addr                    word address, shared by reads and write-backs
//   wr_req/wr_ack/wr_data      write-back handshake carrying the voted value
//   err_strobe                 one-cycle pulse per corrected word
//   err_count                  saturating corrected-word counter
//   last_err_addr              address of the most recently corrected word
//   pass_done                  one-cycle pulse at the end of a full pass
//   busy                       high in READ, VOTE, WRITE, NEXT

module tmr_scrub_ctrl #(
  parameter int WORDS = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4,
  parameter int CNT_W = 8,
  parameter int IV_W  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [IV_W-1:0]  interval,
  input  logic             clear_err,
  output logic             rd_req,
  output logic [AW-1:0]    rd_addr,
  input  logic             rd_ack,
  input  logic [WIDTH-1:0] rd_a,
  input  logic [WIDTH-1:0] rd_b,
  input  logic [WIDTH-1:0] rd_c,
  output logic             wr_req,
  output logic [WIDTH-1:0] wr_data,
  input  logic             wr_ack,
  output logic             err_strobe,
  output logic [CNT_W-1:0] err_count,
  output logic [AW-1:0]    last_err_addr,
  output logic             pass_done,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_READ  = 3'd2,
    ST_VOTE  = 3'd3,
    ST_WRITE = 3'd4,
    ST_NEXT  = 3'd5
  } state_t;

  localparam logic [AW-1:0]    LAST_ADDR = AW'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [IV_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [AW-1:0]    last_err_addr_q, last_err_addr_d;

  logic [WIDTH-1:0] voted;
  logic             mismatch;

  // Copies captured in READ are voted from registers so the bank data only
  // needs to be valid in the rd_ack cycle.
  assign voted    = (a_q & b_q) | (b_q & c_q) | (a_q & c_q);
  assign mismatch = (a_q != b_q) || (b_q != c_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      cnt_q           <= '0;
      a_q             <= '0;
      b_q             <= '0;
      c_q             <= '0;
      wr_data_q       <= '0;
      err_count_q     <= '0;
      last_err_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      cnt_q           <= cnt_d;
      a_q             <= a_d;
      b_q             <= b_d;
      c_q             <= c_d;
      wr_data_q       <= wr_data_d;
      err_count_q     <= err_count_d;
      last_err_addr_q <= last_err_addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    a_d             = a_q;
    b_d             = b_q;
    c_d             = c_q;
    wr_data_d       = wr_data_q;
    err_count_d     = err_count_q;
    last_err_addr_d = last_err_addr_q;
    rd_req          = 1'b0;
    wr_req          = 1'b0;
    err_strobe      = 1'b0;
    pass_done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          cnt_d   = interval;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          addr_d  = '0;
          state_d = ST_READ;
        end else begin
          cnt_d = cnt_q - IV_W'(1);
        end
      end

      // enable is deliberately ignored here and in WRITE: a request, once
      // raised, is held until its ack.
      ST_READ: begin
        rd_req = 1'b1;
        if (rd_ack) begin
          a_d     = rd_a;
          b_d     = rd_b;
          c_d     = rd_c;
          state_d = ST_VOTE;
        end
      end

      ST_VOTE: begin
        if (mismatch) begin
          wr_data_d       = voted;
          err_strobe      = 1'b1;
          last_err_addr_d = addr_q;
          if (err_count_q != CNT_MAX) begin
            err_count_d = err_count_q + CNT_W'(1);
          end
          state_d = ST_WRITE;
        end else begin
          state_d = ST_NEXT;
        end
      end

      ST_WRITE: begin
        wr_req = 1'b1;
        if (wr_ack) begin
          state_d = ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          pass_done = 1'b1;
          addr_d    = '0;
          if (enable) begin
            cnt_d   = interval;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (enable) begin
          addr_d  = addr_q + AW'(1);
          state_d = ST_READ;
        end else begin
          // Abandoned mid-pass: no pass_done, restart from word 0 next time.
          addr_d  = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clear_err) begin
      err_count_d = '0;
    end
  end

  assign rd_addr       = addr_q;
  assign wr_data       = wr_data_q;
  assign err_count     = err_count_q;
  assign last_err_addr = last_err_addr_q;
  assign busy          = (state_q == ST_READ) || (state_q == ST_VOTE) ||
                         (state_q == ST_WRITE) || (state_q == ST_NEXT);

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// tb/tb_tmr_scrub_ctrl.sv - self-checking bench for tmr_scrub_ctrl
module tb_tmr_scrub_ctrl;

  localparam int WORDS = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 4;
  localparam int CNT_W = 2;
  localparam int IV_W  = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             enable = 1'b0;
  logic [IV_W-1:0]  interval = '0;
  logic             clear_err = 1'b0;
  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic             rd_ack;
  logic [WIDTH-1:0] rd_a, rd_b, rd_c;
  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ack;
  logic             err_strobe;
  logic [CNT_W-1:0] err_count;
  logic [AW-1:0]    last_err_addr;
  logic             pass_done;
  logic             busy;

  tmr_scrub_ctrl #(
    .WORDS(WORDS), .WIDTH(WIDTH), .AW(AW), .CNT_W(CNT_W), .IV_W(IV_W)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .interval(interval),
    .clear_err(clear_err), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .err_strobe(err_strobe), .err_count(err_count),
    .last_err_addr(last_err_addr), .pass_done(pass_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register bank model: three copies per word, ack latency programmable.
  logic [WIDTH-1:0] mem_a [WORDS];
  logic [WIDTH-1:0] mem_b [WORDS];
  logic [WIDTH-1:0] mem_c [WORDS];
  int rd_lat = 0, wr_lat = 0, rd_cnt = 0, wr_cnt = 0;
  int cyc = 0;

  assign rd_ack = rd_req && (rd_cnt >= rd_lat);
  assign wr_ack = wr_req && (wr_cnt >= wr_lat);
  assign rd_a   = mem_a[rd_addr];
  assign rd_b   = mem_b[rd_addr];
  assign rd_c   = mem_c[rd_addr];

  always @(posedge clk) begin
    rd_cnt <= (rd_req && !rd_ack) ? rd_cnt + 1 : 0;
    wr_cnt <= (wr_req && !wr_ack) ? wr_cnt + 1 : 0;
    cyc    <= cyc + 1;
  end

  // Event log, sampled mid-cycle.
  logic             log_clr = 1'b0;
  bit               strobe_seen [WORDS];
  bit               wr_seen [WORDS];
  logic [WIDTH-1:0] wr_val [WORDS];
  int strobe_total = 0, wr_total = 0, pd_count = 0;

  always @(negedge clk) begin
    if (log_clr) begin
      for (int i = 0; i < WORDS; i++) begin
        strobe_seen[i] = 1'b0;
        wr_seen[i]     = 1'b0;
        wr_val[i]      = '0;
      end
      strobe_total = 0;
      wr_total     = 0;
    end else begin
      if (pass_done) pd_count++;
      if (err_strobe) begin
        strobe_seen[rd_addr] = 1'b1;
        strobe_total++;
      end
      if (wr_req && wr_ack) begin
        wr_seen[rd_addr] = 1'b1;
        wr_val[rd_addr]  = wr_data;
        wr_total++;
      end
    end
  end

  typedef struct {
    logic [WIDTH-1:0] a, b, c, v;
    bit               mm;
  } vec_t;
  vec_t tbl [8];

  int checks = 0, failures = 0;

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_pd(input string name);
    int n = 0;
    while (!pass_done && n < 3000) begin
      tick;
      n++;
    end
    if (!pass_done) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic clear_log;
    log_clr = 1'b1;
    tick;
    log_clr = 1'b0;
  endtask

  task automatic fill_clean;
    for (int i = 0; i < WORDS; i++) begin
      mem_a[i] = WIDTH'(i * 17 + 3);
      mem_b[i] = WIDTH'(i * 17 + 3);
      mem_c[i] = WIDTH'(i * 17 + 3);
    end
  endtask

  task automatic run_pass(input string name);
    clear_log;
    enable = 1'b1;
    tick;
    wait_pd(name);
    enable = 1'b0;
    repeat (3) tick;
  endtask

  int t1, t2, n, held, pd0;

  initial begin
    tbl[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1};
    tbl[2] = '{8'h0F, 8'hF0, 8'hFF, 8'hFF, 1'b1};
    tbl[3] = '{8'h12, 8'h34, 8'h12, 8'h12, 1'b1};
    tbl[4] = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 1'b0};
    tbl[5] = '{8'h81, 8'h81, 8'h7E, 8'h81, 1'b1};
    tbl[6] = '{8'h3C, 8'hC3, 8'h00, 8'h00, 1'b1};
    tbl[7] = '{8'h55, 8'h55, 8'h55, 8'h55, 1'b0};

    fill_clean;
    repeat (3) tick;
    chk("rst_rd_req", int'(rd_req), 0);
    chk("rst_wr_req", int'(wr_req), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_last_err_addr", int'(last_err_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pass_done", int'(pass_done), 0);
    rstn = 1'b1;
    repeat (2) tick;
    chk("idle_busy", int'(busy), 0);

    // Clean pass, interval 5: 16*3 + 6 cycles between pass_done pulses.
    interval = 16'd5;
    clear_log;
    enable = 1'b1;
    wait_pd("clean1");
    t1 = cyc;
    tick;
    wait_pd("clean2");
    t2 = cyc;
    enable = 1'b0;
    repeat (3) tick;
    chk("clean_period", t2 - t1, 54);
    chk("clean_wr_total", wr_total, 0);
    chk("clean_strobes", strobe_total, 0);
    chk("clean_err_count", int'(err_count), 0);

    // Single upset on word 7.
    fill_clean;
    mem_a[7] = 8'h5A; mem_b[7] = 8'h5B; mem_c[7] = 8'h5A;
    interval = '0;
    run_pass("upset");
    chk("upset_wr_total", wr_total, 1);
    chk("upset_wr_addr7", int'(wr_seen[7]), 1);
    chk("upset_wr_data", int'(wr_val[7]), 8'h5A);
    chk("upset_strobes", strobe_total, 1);
    chk("upset_err_count", int'(err_count), 1);
    chk("upset_last_addr", int'(last_err_addr), 7);

    // Vote table on words 0..7; five mismatches saturate the 2-bit counter.
    fill_clean;
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = tbl[i].a; mem_b[i] = tbl[i].b; mem_c[i] = tbl[i].c;
    end
    run_pass("table");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tbl%0d_strobe", i), int'(strobe_seen[i]), int'(tbl[i].mm));
      chk($sformatf("tbl%0d_wr", i), int'(wr_seen[i]), int'(tbl[i].mm));
      chk($sformatf("tbl%0d_wr_data", i), int'(wr_val[i]), tbl[i].mm ? int'(tbl[i].v) : 0);
    end
    chk("sat_err_count", int'(err_count), 3);
    chk("sat_strobes", strobe_total, 5);
    chk("sat_last_addr", int'(last_err_addr), 6);

    // clear_err in the same cycle as a VOTE mismatch.
    fill_clean;
    mem_a[2] = 8'h01; mem_b[2] = 8'h00; mem_c[2] = 8'h00;
    clear_log;
    enable = 1'b1;
    n = 0;
    while (!(rd_req && rd_ack && rd_addr == 4'd2) && n < 200) begin
      tick;
      n++;
    end
    chk("clr_reach_read2", int'(rd_req && rd_ack && rd_addr == 4'd2), 1);
    tick;
    chk("clr_vote_strobe", int'(err_strobe), 1);
    chk("clr_pre_count", int'(err_count), 3);
    clear_err = 1'b1;
    tick;
    clear_err = 1'b0;
    chk("clr_err_count", int'(err_count), 0);
    chk("clr_last_addr", int'(last_err_addr), 2);
    wait_pd("clr");
    enable = 1'b0;
    repeat (3) tick;
    chk("clr_end_count", int'(err_count), 0);

    // Enable drop at WRITE cycle 1 with wr_ack delayed 4 cycles.
    fill_clean;
    mem_b[3] = ~mem_b[3];
    wr_lat = 4;
    clear_log;
    pd0 = pd_count;
    enable = 1'b1;
    n = 0;
    while (!wr_req && n < 200) begin
      tick;
      n++;
    end
    chk("drop_reach_write", int'(wr_req), 1);
    chk("drop_write_addr", int'(rd_addr), 3);
    enable = 1'b0;
    held = 0;
    n = 0;
    while (n < 50) begin
      if (wr_req) held++;
      if (wr_req && wr_ack) break;
      tick;
      n++;
    end
    chk("drop_wr_held", held, 5);
    tick;
    chk("drop_next_busy", int'(busy), 1);
    chk("drop_next_pd", int'(pass_done), 0);
    tick;
    chk("drop_idle_busy", int'(busy), 0);
    chk("drop_idle_addr", int'(rd_addr), 0);
    repeat (4) tick;
    chk("drop_no_pd", pd_count - pd0, 0);
    chk("drop_wr_data", int'(wr_val[3]), 3 * 17 + 3);
    chk("drop_err_count", int'(err_count), 1);
    wr_lat = 0;

    // Asynchronous reset while a read is pending.
    fill_clean;
    rd_lat = 3;
    interval = '0;
    enable = 1'b1;
    n = 0;
    while (!(rd_req && rd_addr == 4'd5) && n < 300) begin
      tick;
      n++;
    end
    chk("rst_reach_read5", int'(rd_req && rd_addr == 4'd5), 1);
    rstn = 1'b0;
    #1;
    chk("arst_rd_req", int'(rd_req), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_rd_addr", int'(rd_addr), 0);
    chk("arst_err_count", int'(err_count), 0);
    rd_lat = 0;
    repeat (2) tick;
    rstn = 1'b1;
    n = 0;
    while (!rd_req && n < 20) begin
      tick;
      n++;
    end
    chk("restart_latency", n, 2);
    chk("restart_addr", int'(rd_addr), 0);

    // interval 0: one WAIT cycle between passes.
    wait_pd("iv0_a");
    t1 = cyc;
    tick;
    wait_pd("iv0_b");
    t2 = cyc;
    enable = 1'b0;
    repeat (3) tick;
    chk("iv0_period", t2 - t1, 3 * WORDS + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
